dual_port_ram_port_controller: RTL and testbench
================================================

// Module: dual_port_ram_port_controller
// PURPOSE
//  Requester-side controller for one port of dual_port_ram. It converts a valid/ready
//  request stream into the RAM's raw protocol: we, address, data_in and 1-cycle data_out.
//  After reset it clears every RAM entry. It buffers read data so the consumer can apply
//  backpressure. One instance sits between a core/cache client and each RAM port.
// PARAMETERS
//  DATA_WIDTH     32  word width; must match the RAM
//  ADDRESS_WIDTH  32  address width; must match the RAM
//  INDEX_BITS     6   RAM depth = 2**INDEX_BITS entries; must match the RAM
//  RESP_DEPTH     4   read-response buffer entries; power of two, >=2
//  CLEAR_ON_RESET 1   1: run INIT sweep after reset; 0: go straight to SERVE
//  INIT_VALUE     0   DATA_WIDTH value written to every entry during INIT
// PORTS
//  clock          in   1    rising-edge clock
//  reset          in   1    synchronous, active-high reset
//  req_valid      in   1    request present
//  req_ready      out  1    controller accepts request this cycle
//  req_write      in   1    1=write, 0=read
//  req_address    in   AW   request address; RAM decodes low INDEX_BITS
//  req_data       in   DW   write data
//  resp_valid     out  1    read response at buffer head
//  resp_ready     in   1    consumer takes response this cycle
//  resp_data      out  DW   read data
//  resp_address   out  AW   address of the read being returned
//  init_done      out  1    1 once INIT sweep is finished
//  ram_we         out  1    to RAM we
//  ram_address    out  AW   to RAM address
//  ram_data_in    out  DW   to RAM data_in
//  ram_data_out   in   DW   from RAM data_out, valid 1 cycle after a read address
// BEHAVIOUR
//  Reset values: state=INIT (SERVE if CLEAR_ON_RESET=0), init counter=0, buffer empty,
//   in-flight flag=0, resp_valid=0, req_ready=0, init_done=CLEAR_ON_RESET?0:1.
//  While reset is high, ram_we=0.
//  INIT: ram_we=1, ram_address=zero-extended counter, ram_data_in=INIT_VALUE, req_ready=0.
//   The counter goes +1 per cycle. After the write at 2**INDEX_BITS-1: go to SERVE,
//   init_done=1 the next cycle. The sweep takes exactly 2**INDEX_BITS cycles.
//  SERVE: accept = req_valid & req_ready.
//   req_ready = (count + inflight) < RESP_DEPTH. It uses registered state only, so
//   there is no combinational path from resp_ready.
//   Accepted write in cycle N: ram_we=1 with req_address/req_data in cycle N.
//    Writes produce no response.
//   Accepted read in cycle N: ram_we=0, ram_address=req_address in cycle N. inflight=1 with
//    the address saved. In cycle N+1, ram_data_out and the saved address are pushed into the
//    buffer. resp_valid rises in cycle N+2. Read latency is 2 cycles.
//   No accept: ram_we=0; ram_address holds its last value.
//   Pop = resp_valid & resp_ready. Push and pop may happen in the same cycle; count is
//    then unchanged.
//  Ordering: requests execute in acceptance order. A read at N followed by a write to the
//   same address at N+1 returns the old data. A write at N followed by a read at N+1
//   returns the new data.
//  Buffer-full case: the credit rule guarantees a push never overflows. With RESP_DEPTH>=3,
//   back-to-back reads sustain 1/cycle while resp_ready=1.
//  Buffer-empty case: resp_valid=0; resp_data/resp_address are don't-care.
//  Buffer pointers wrap modulo RESP_DEPTH.
//  Reset mid-operation: in-flight read and buffered responses are discarded. INIT restarts
//   from entry 0.
//  Width rules: count is $clog2(RESP_DEPTH)+1 bits. The init counter is INDEX_BITS+1 bits,
//   so the terminal test does not wrap.
// STRUCTURE
//  State encoding (INIT, SERVE) is a localparam inside this module; nothing goes in the
//   shared defines.
//  One sub-module: response_fifo, a synchronous FIFO with parameters WIDTH=DW+AW and DEPTH.
//   Ports: push, pop, data_in, data_out, empty, count.
//  Top level holds the FSM, init counter, in-flight register and RAM output muxing.
// TESTING
//  Bench pairs the block with dual_port_ram, INDEX_BITS=4, RESP_DEPTH=4, INIT_VALUE=32'hA5A5A5A5.
//  1 Reset, then idle -> ram_we=1 for 16 cycles on addrs 0..15, then init_done=1.
//    A read of addr 7 returns 32'hA5A5A5A5.
//  2 Write 3<=32'hDEADBEEF at N, read 3 at N+1 -> resp_valid at N+3,
//    resp_data=32'hDEADBEEF, resp_address=3.
//  3 resp_ready=0 and 6 back-to-back reads -> exactly 4 accepted and req_ready=0.
//    Then resp_ready=1 -> 4 responses in order, then the remaining 2 are accepted.
//  4 resp_ready=1 and 8 back-to-back reads -> req_ready stays 1 and resp_valid is high for
//    8 consecutive cycles starting 2 cycles after the first accept.
//  5 Read 5 at N and write 5<=32'h1 at N+1 (entry held 32'h0) -> response data 32'h0.
//  6 reset pulse while 2 responses are buffered and init is done -> resp_valid=0 the next
//    cycle, init_done=0, INIT sweep restarts at addr 0.

Source files
------------

// File: rtl/dual_port_ram_port_controller_pkg.sv
// rtl/dual_port_ram_port_controller_pkg.sv - shared defaults, request kind and sizing helper
//
// Contents:
//   DEFAULT_*      default parameter values for the port controller
//   req_kind_e     meaning of the req_write bit
//   count_width()  bits needed to hold an occupancy count of 0..depth

package dual_port_ram_port_controller_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_INDEX_BITS    = 6;
    localparam int DEFAULT_RESP_DEPTH    = 4;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    // An occupancy count must reach depth itself, hence one bit above the pointer width.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dual_port_ram_port_controller_if.sv
// rtl/dual_port_ram_port_controller_if.sv - request/response/RAM bus of one RAM port
//
// Signals:
//   req_valid/req_ready/req_write/req_address/req_data   client request stream
//   resp_valid/resp_ready/resp_data/resp_address         read response stream
//   init_done                                            clear sweep finished
//   ram_we/ram_address/ram_data_in/ram_data_out          raw RAM port
// Modports:
//   master  the port controller
//   slave   the client plus RAM side

interface dual_port_ram_port_controller_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0]    req_data;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_WIDTH-1:0]    resp_data;
    logic [ADDRESS_WIDTH-1:0] resp_address;

    logic                     init_done;

    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0]    ram_data_in;
    logic [DATA_WIDTH-1:0]    ram_data_out;

    modport master (
        input  req_valid, req_write, req_address, req_data,
        output req_ready,
        output resp_valid, resp_data, resp_address,
        input  resp_ready,
        output init_done,
        output ram_we, ram_address, ram_data_in,
        input  ram_data_out
    );

    modport slave (
        output req_valid, req_write, req_address, req_data,
        input  req_ready,
        input  resp_valid, resp_data, resp_address,
        output resp_ready,
        input  init_done,
        input  ram_we, ram_address, ram_data_in,
        output ram_data_out
    );

endinterface

// File: rtl/dual_port_ram_port_controller_response_fifo.sv
// rtl/dual_port_ram_port_controller_response_fifo.sv - synchronous FIFO buffering read responses
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-high reset, empties the FIFO
//   push      write data_in this cycle (ignored when full and not popping)
//   pop       drop the head entry this cycle (ignored when empty)
//   data_in   entry to store
//   data_out  head entry, meaningless while empty
//   empty     no entries held
//   count     number of entries held, 0..DEPTH

module response_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count_q != '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO is still safe then.
    assign do_push = push & ((count_q != FULL_COUNT) | do_pop);

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH on natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_out = mem[rd_ptr];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/dual_port_ram_port_controller.sv
// rtl/dual_port_ram_port_controller.sv - requester-side controller for one dual_port_ram port
//
// Converts a valid/ready request stream into the RAM's raw we/address/data protocol,
// clears every RAM entry after reset, and buffers read data so the consumer can stall.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    request, response, init_done and RAM signals (master modport)
//
// Read timing: accepted in cycle N, RAM data returns in N+1 and is pushed into the
// response buffer together with the saved address, resp_valid in N+2.

module dual_port_ram_port_controller
    import dual_port_ram_port_controller_pkg::*;
#(
    parameter int                    DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int                    ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
    parameter int                    INDEX_BITS     = DEFAULT_INDEX_BITS,
    parameter int                    RESP_DEPTH     = DEFAULT_RESP_DEPTH,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    dual_port_ram_port_controller_if.master bus
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int IW      = INDEX_BITS + 1;
    localparam int CW      = count_width(RESP_DEPTH);
    localparam int SW      = CW + 1;
    localparam int EW      = DATA_WIDTH + ADDRESS_WIDTH;

    localparam logic [IW-1:0] INIT_LAST   = IW'(ENTRIES - 1);
    localparam logic [SW-1:0] DEPTH_LIMIT = SW'(RESP_DEPTH);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_SERVE;

    state_e                   state_q;
    state_e                   state_d;
    logic [IW-1:0]            init_cnt_q;
    logic                     init_done_q;
    logic                     inflight_q;
    logic [ADDRESS_WIDTH-1:0] inflight_addr_q;
    logic [ADDRESS_WIDTH-1:0] ram_address_q;

    logic                     ready;
    logic                     accept;
    logic                     read_accept;
    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0]    ram_data_in;
    logic [SW-1:0]            credits_used;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic [EW-1:0]            fifo_in;
    logic [EW-1:0]            fifo_out;

    // Buffered entries plus the read still in the RAM pipeline: a read is accepted
    // only when a buffer slot is guaranteed for it. Registered terms only.
    assign credits_used = SW'(fifo_count) + SW'(inflight_q);

    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        accept      = 1'b0;
        read_accept = 1'b0;
        ram_we      = 1'b0;
        ram_address = ram_address_q;
        ram_data_in = bus.req_data;

        case (state_q)
            ST_INIT: begin
                ram_we      = 1'b1;
                ram_address = ADDRESS_WIDTH'(init_cnt_q);
                ram_data_in = INIT_VALUE;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                ready = (credits_used < DEPTH_LIMIT);
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        if (reset) begin
            ready = 1'b0;
        end

        accept      = bus.req_valid & ready;
        read_accept = accept & (bus.req_write == REQ_READ);

        if (accept) begin
            ram_we      = (bus.req_write == REQ_WRITE);
            ram_address = bus.req_address;
        end

        // The RAM must never see a write while the controller is held in reset.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RESET_STATE;
            init_cnt_q      <= '0;
            init_done_q     <= !CLEAR_ON_RESET;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            ram_address_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            if (state_d == ST_SERVE) begin
                init_done_q <= 1'b1;
            end
            inflight_q <= read_accept;
            if (read_accept) begin
                inflight_addr_q <= bus.req_address;
            end
            ram_address_q <= ram_address;
        end
    end

    // The RAM answers one cycle after the read address, so the in-flight flag marks
    // the cycle in which ram_data_out belongs to the saved address.
    assign fifo_push = inflight_q;
    assign fifo_in   = {bus.ram_data_out, inflight_addr_q};
    assign fifo_pop  = ~fifo_empty & bus.resp_ready;

    response_fifo #(
        .WIDTH (EW),
        .DEPTH (RESP_DEPTH)
    ) u_response_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .data_in  (fifo_in),
        .data_out (fifo_out),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bus.req_ready    = ready;
    assign bus.resp_valid   = ~fifo_empty;
    assign bus.resp_data    = fifo_out[EW-1 -: DATA_WIDTH];
    assign bus.resp_address = fifo_out[ADDRESS_WIDTH-1:0];
    assign bus.init_done    = init_done_q;
    assign bus.ram_we       = ram_we;
    assign bus.ram_address  = ram_address;
    assign bus.ram_data_in  = ram_data_in;

endmodule

// File: tb/tb_dual_port_ram_port_controller.sv
// tb/tb_dual_port_ram_port_controller.sv - self-checking bench for dual_port_ram_port_controller

module tb_dual_port_ram_port_controller;

    localparam logic [31:0] INIT_WORD = 32'hA5A5A5A5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    dual_port_ram_port_controller_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    dual_port_ram_port_controller #(
        .DATA_WIDTH     (32),
        .ADDRESS_WIDTH  (32),
        .INDEX_BITS     (4),
        .RESP_DEPTH     (4),
        .CLEAR_ON_RESET (1'b1),
        .INIT_VALUE     (INIT_WORD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Environment RAM: registered read, old data returned when the same entry is written.
    logic [31:0] ram_mem [16];
    always @(posedge clock) begin
        if (bus.ram_we) ram_mem[bus.ram_address[3:0]] <= bus.ram_data_in;
        bus.ram_data_out <= ram_mem[bus.ram_address[3:0]];
    end

    // Reference model: requests take effect in acceptance order; a read yields the
    // entry's contents at the moment it is accepted.
    logic [31:0] model_mem [16];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            got_q.delete();
            for (int i = 0; i < 16; i++) model_mem[i] <= INIT_WORD;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_write) model_mem[bus.req_address[3:0]] <= bus.req_data;
                else exp_q.push_back({model_mem[bus.req_address[3:0]], bus.req_address});
            end
            if (bus.resp_valid && bus.resp_ready)
                got_q.push_back({bus.resp_data, bus.resp_address});
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_address = a;
        bus.req_data    = d;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            got = bus.req_ready;
            next_cycle();
        end
        bus.req_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL req_accept_timeout addr=%h accepted=%0d required=1", a, got);
        end
    endtask

    task automatic wait_drain(output bit ok);
        bus.resp_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            next_cycle();
            ok = (got_q.size() == exp_q.size()) && !bus.resp_valid;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_address = 32'h3;
        bus.req_data = 32'h1234;
        repeat (2) next_cycle();
        @(negedge clock);
        total++;
        if (bus.ram_we !== 1'b0 || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs we=%b ready=%b rv=%b required 0 0 0", bus.ram_we, bus.req_ready, bus.resp_valid);
        end
        next_cycle();
        bus.req_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            total++;
            if (bus.ram_we !== 1'b1 || bus.ram_address !== 32'(i) || bus.ram_data_in !== INIT_WORD ||
                bus.init_done !== 1'b0 || bus.req_ready !== 1'b0) begin
                bad++;
                $display("FAIL init_sweep_%0d we=%b addr=%h data=%h done=%b ready=%b required 1 %h %h 0 0",
                         i, bus.ram_we, bus.ram_address, bus.ram_data_in, bus.init_done, bus.req_ready, i, INIT_WORD);
            end
            next_cycle();
        end
        @(negedge clock);
        total++;
        if (bus.init_done !== 1'b1 || bus.ram_we !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL init_end done=%b we=%b ready=%b required 1 0 1", bus.init_done, bus.ram_we, bus.req_ready);
        end
        next_cycle();
    endtask

    task automatic test_init_read();
        bit ok;
        exp_q.delete();
        got_q.delete();
        do_req(1'b0, 32'd7, $urandom);
        wait_drain(ok);
        total++;
        if (!ok || got_q.size() != 1) begin
            bad++;
            $display("FAIL init_read_count got=%0d required=1", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== {INIT_WORD, 32'd7} || got_q[0] !== exp_q[0]) begin
                bad++;
                $display("FAIL init_read_data got=%h required=%h", got_q[0], {INIT_WORD, 32'd7});
            end
        end
    endtask

    task automatic test_write_then_read();
        bit ok;
        exp_q.delete();
        got_q.delete();
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_address = 32'd3;
        bus.req_data = 32'hDEADBEEF;
        @(negedge clock);
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL wr_rd_write_ready got=%b required=1", bus.req_ready); end
        next_cycle();
        bus.req_write = 1'b0;
        bus.req_data = $urandom;
        @(negedge clock);
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL wr_rd_read_ready got=%b required=1", bus.req_ready); end
        next_cycle();
        bus.req_valid = 1'b0;
        @(negedge clock);
        total++;
        if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_early_valid got=%b required=0", bus.resp_valid); end
        next_cycle();
        @(negedge clock);
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hDEADBEEF || bus.resp_address !== 32'd3) begin
            bad++;
            $display("FAIL wr_rd_response rv=%b data=%h addr=%h required 1 deadbeef 00000003",
                     bus.resp_valid, bus.resp_data, bus.resp_address);
        end
        next_cycle();
        wait_drain(ok);
        total++;
        if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL wr_rd_scoreboard count=%0d required=1", got_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a [6];
        int acc;
        bit ok;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a[i] = $urandom;
            do_req(1'b1, a[i], $urandom);
        end
        exp_q.delete();
        got_q.delete();
        acc = 0;
        bus.req_write = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.req_valid = 1'b1;
            bus.req_address = a[acc];
            @(negedge clock);
            if (bus.req_ready) acc++;
            next_cycle();
        end
        bus.req_address = a[acc];
        @(negedge clock);
        total++;
        if (acc != 4) begin bad++; $display("FAIL bp_accepted got=%0d required=4", acc); end
        total++;
        if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b required=0", bus.req_ready); end
        next_cycle();
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 30 && acc < 6; c++) begin
            bus.req_address = a[acc];
            @(negedge clock);
            if (bus.req_ready) acc++;
            next_cycle();
        end
        bus.req_valid = 1'b0;
        wait_drain(ok);
        total++;
        if (!ok || got_q.size() != 6 || exp_q.size() != 6) begin
            bad++;
            $display("FAIL bp_resp_count got=%0d required=6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (got_q[i] !== exp_q[i] || got_q[i][31:0] !== a[i]) begin
                    bad++;
                    $display("FAIL bp_resp_%0d got=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] rv;
        bit ready_ok;
        bit ok;
        exp_q.delete();
        got_q.delete();
        bus.resp_ready = 1'b1;
        bus.req_write = 1'b0;
        ready_ok = 1;
        rv = '0;
        for (int c = 0; c < 12; c++) begin
            bus.req_valid = (c < 8);
            bus.req_address = $urandom;
            @(negedge clock);
            if (c < 8 && bus.req_ready !== 1'b1) ready_ok = 0;
            rv[c] = bus.resp_valid;
            next_cycle();
        end
        bus.req_valid = 1'b0;
        total++;
        if (!ready_ok) begin bad++; $display("FAIL b2b_ready got=0 required=1"); end
        total++;
        if (rv !== 12'h3FC) begin bad++; $display("FAIL b2b_valid_window got=%h required=3fc", rv); end
        wait_drain(ok);
        total++;
        if (!ok || got_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_count got=%0d required=8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_resp_%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_read_before_write();
        bit ok;
        do_req(1'b1, 32'd5, 32'h0);
        exp_q.delete();
        got_q.delete();
        do_req(1'b0, 32'd5, $urandom);
        do_req(1'b1, 32'd5, 32'h1);
        do_req(1'b0, 32'd5, $urandom);
        wait_drain(ok);
        total++;
        if (!ok || got_q.size() != 2) begin
            bad++;
            $display("FAIL rbw_count got=%0d required=2", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== {32'h0, 32'd5} || got_q[0] !== exp_q[0]) begin
                bad++;
                $display("FAIL rbw_old_data got=%h required=%h", got_q[0], {32'h0, 32'd5});
            end
            total++;
            if (got_q[1] !== {32'h1, 32'd5} || got_q[1] !== exp_q[1]) begin
                bad++;
                $display("FAIL rbw_new_data got=%h required=%h", got_q[1], {32'h1, 32'd5});
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bus.resp_ready = 1'b0;
        do_req(1'b0, $urandom, 32'h0);
        do_req(1'b0, $urandom, 32'h0);
        repeat (3) next_cycle();
        @(negedge clock);
        total++;
        if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_buffered got=%b required=1", bus.resp_valid); end
        next_cycle();
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_address = 32'd9;
        @(negedge clock);
        total++;
        if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rst_mid_we got=%b required=0", bus.ram_we); end
        next_cycle();
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        total++;
        if (bus.resp_valid !== 1'b0 || bus.init_done !== 1'b0 || bus.ram_we !== 1'b1 || bus.ram_address !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_restart rv=%b done=%b we=%b addr=%h required 0 0 1 0",
                     bus.resp_valid, bus.init_done, bus.ram_we, bus.ram_address);
        end
        next_cycle();
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            total++;
            if (bus.ram_we !== 1'b1 || bus.ram_address !== 32'(i)) begin
                bad++;
                $display("FAIL rst_mid_sweep_%0d we=%b addr=%h required 1 %h", i, bus.ram_we, bus.ram_address, i);
            end
            next_cycle();
        end
        @(negedge clock);
        total++;
        if (bus.init_done !== 1'b1 || bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_done done=%b rv=%b required 1 0", bus.init_done, bus.resp_valid);
        end
        next_cycle();
    endtask

    task automatic test_random_traffic();
        bit pending;
        bit ok;
        int issued;
        exp_q.delete();
        got_q.delete();
        pending = 0;
        issued = 0;
        for (int c = 0; c < 600 && issued < 80; c++) begin
            if (!pending && ($urandom_range(3) != 0)) begin
                bus.req_valid = 1'b1;
                bus.req_write = $urandom_range(1);
                bus.req_address = {$urandom_range(3), 26'h0, 4'($urandom)};
                bus.req_data = $urandom;
                pending = 1;
            end
            bus.resp_ready = ($urandom_range(2) != 0);
            @(negedge clock);
            if (pending && bus.req_ready) begin
                pending = 0;
                issued++;
            end
            next_cycle();
            if (!pending) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        total++;
        if (issued != 80) begin bad++; $display("FAIL rand_issued got=%0d required=80", issued); end
        wait_drain(ok);
        total++;
        if (!ok || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_resp_%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = '0;
        bus.req_data    = '0;
        bus.resp_ready  = 1'b0;
        next_cycle();
        test_reset();
        test_init_read();
        test_write_then_read();
        test_backpressure();
        test_back_to_back();
        test_read_before_write();
        test_reset_mid_op();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
